// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared encodings and constants for the instruction fetch sequencer.
// Pure declarations: no logic, no latency, no flow control.
// Imported by ifu_fetch_ctrl and available to benches and neighbouring blocks.
package ifu_fetch_ctrl_pkg;

    localparam int          IFC_CPU_WIDTH = 64;
    localparam int          IFC_INS_W     = 32;
    localparam logic [63:0] IFC_RESET_PC  = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IFC_IDLE = 2'd0,
        IFC_REQ  = 2'd1,
        IFC_WAIT = 2'd2,
        IFC_HOLD = 2'd3
    } ifc_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one-outstanding fetches, holds each instruction for decode.
// Latency: request 1 cycle after reset/consume/redirect; instruction valid the cycle after rvalid.
// Backpressure: o_mem_req/addr held until gnt; o_ins held until i_ins_ready; redirect overrides both.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                   CPU_WIDTH = IFC_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFC_RESET_PC)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_mem_req,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [IFC_INS_W-1:0] i_mem_rdata,
    output logic                 o_ins_valid,
    input  logic                 i_ins_ready,
    output logic [IFC_INS_W-1:0] o_ins,
    output logic [CPU_WIDTH-1:0] o_ins_pc,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc
);

    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

    ifc_state_e           state, state_nxt;
    logic [CPU_WIDTH-1:0] pc, pc_nxt;
    logic [CPU_WIDTH-1:0] redirect_tgt;
    logic                 drop, drop_nxt;
    logic                 ins_load;
    logic [IFC_INS_W-1:0] ins_q;
    logic [CPU_WIDTH-1:0] ins_pc_q;
    logic                 unused_redirect_lsb;

    // Instructions are word aligned; low target bits are discarded.
    assign redirect_tgt        = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        ins_load  = 1'b0;
        if (i_redirect) begin
            pc_nxt = redirect_tgt;
            unique case (state)
                IFC_REQ: begin
                    // A request granted alongside the redirect is already stale.
                    if (i_mem_gnt) begin
                        drop_nxt  = 1'b1;
                        state_nxt = IFC_WAIT;
                    end else begin
                        state_nxt = IFC_REQ;
                    end
                end
                IFC_WAIT: begin
                    if (i_mem_rvalid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = IFC_REQ;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IFC_REQ;
            endcase
        end else begin
            unique case (state)
                IFC_IDLE: state_nxt = IFC_REQ;
                IFC_REQ: begin
                    if (i_mem_gnt) begin
                        state_nxt = IFC_WAIT;
                    end
                end
                IFC_WAIT: begin
                    if (i_mem_rvalid) begin
                        if (drop) begin
                            drop_nxt  = 1'b0;
                            state_nxt = IFC_REQ;
                        end else begin
                            ins_load  = 1'b1;
                            state_nxt = IFC_HOLD;
                        end
                    end
                end
                IFC_HOLD: begin
                    if (i_ins_ready) begin
                        pc_nxt    = pc + PC_STEP;
                        state_nxt = IFC_REQ;
                    end
                end
                default: state_nxt = IFC_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IFC_IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            ins_q    <= '0;
            ins_pc_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
            if (ins_load) begin
                ins_q    <= i_mem_rdata;
                ins_pc_q <= pc;
            end
        end
    end

    assign o_mem_req   = (state == IFC_REQ);
    assign o_mem_addr  = pc;
    assign o_ins_valid = (state == IFC_HOLD);
    assign o_ins       = ins_q;
    assign o_ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed cycle table, reset-in-flight sequence, randomized run vs reference model.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [63:0] ins_pc;
    logic        redirect;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(.CPU_WIDTH(64), .RESET_PC(64'h0000_0000_8000_0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_ins_valid   (ins_valid),
        .i_ins_ready   (ins_ready),
        .o_ins         (ins),
        .o_ins_pc      (ins_pc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [63:0] e_addr,
                            input logic e_vld, input logic [31:0] e_ins, input logic [63:0] e_pc);
        chk({tag, ".mem_req"},   {63'd0, mem_req},   {63'd0, e_req});
        chk({tag, ".mem_addr"},  mem_addr,           e_addr);
        chk({tag, ".ins_valid"}, {63'd0, ins_valid}, {63'd0, e_vld});
        chk({tag, ".ins"},       {32'd0, ins},       {32'd0, e_ins});
        chk({tag, ".ins_pc"},    ins_pc,             e_pc);
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [63:0] rpc);
        mem_gnt     = g;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        ins_ready   = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
    endtask

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5a5a_1234;
    endfunction

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [63:0] rpc;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [63:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic rdr, input logic [63:0] rpc, input logic e_req,
                                input logic [63:0] e_addr, input logic e_vld, input logic [31:0] e_ins,
                                input logic [63:0] e_pc);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    localparam logic [63:0] B  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TF = 64'hffff_ffff_ffff_fffc;
    localparam logic [31:0] D0 = 32'h1111_0001, D1 = 32'h2222_0002, D2 = 32'h3333_0003;
    localparam logic [31:0] D3 = 32'h4444_0004, D4 = 32'h5555_0005, D5 = 32'h6666_0006;
    localparam logic [31:0] DX = 32'hdead_beef;

    vec_t tbl[31];

    // Reference model: fetch progress described as started / outstanding / holding / stale.
    bit          m_started, m_out, m_have, m_stale;
    logic [63:0] m_pc, m_ins_pc;
    logic [31:0] m_ins;
    bit          mem_busy;
    int          mem_cnt;
    logic [63:0] mem_a;

    initial begin
        //                g  rv rdata rdy rdr rpc                  req addr           vld ins pc
        tbl[0]  = mk(1, 0, 0,  1, 0, 0,                    1, B,             0, 0,  0);
        tbl[1]  = mk(1, 0, 0,  1, 0, 0,                    0, B,             0, 0,  0);
        tbl[2]  = mk(0, 1, D0, 1, 0, 0,                    0, B,             1, D0, B);
        tbl[3]  = mk(0, 0, 0,  1, 0, 0,                    1, B + 64'h4,     0, D0, B);
        tbl[4]  = mk(1, 0, 0,  1, 0, 0,                    0, B + 64'h4,     0, D0, B);
        tbl[5]  = mk(0, 1, D1, 0, 0, 0,                    0, B + 64'h4,     1, D1, B + 64'h4);
        tbl[6]  = mk(0, 0, 0,  0, 0, 0,                    0, B + 64'h4,     1, D1, B + 64'h4);
        tbl[7]  = mk(1, 1, DX, 0, 0, 0,                    0, B + 64'h4,     1, D1, B + 64'h4);
        tbl[8]  = mk(0, 0, 0,  1, 0, 0,                    1, B + 64'h8,     0, D1, B + 64'h4);
        tbl[9]  = mk(0, 0, 0,  1, 0, 0,                    1, B + 64'h8,     0, D1, B + 64'h4);
        tbl[10] = mk(0, 0, 0,  1, 0, 0,                    1, B + 64'h8,     0, D1, B + 64'h4);
        tbl[11] = mk(1, 0, 0,  1, 0, 0,                    0, B + 64'h8,     0, D1, B + 64'h4);
        tbl[12] = mk(0, 0, 0,  1, 1, B + 64'h103,          0, B + 64'h100,   0, D1, B + 64'h4);
        tbl[13] = mk(0, 1, DX, 1, 0, 0,                    1, B + 64'h100,   0, D1, B + 64'h4);
        tbl[14] = mk(1, 0, 0,  1, 0, 0,                    0, B + 64'h100,   0, D1, B + 64'h4);
        tbl[15] = mk(0, 1, D2, 0, 0, 0,                    0, B + 64'h100,   1, D2, B + 64'h100);
        tbl[16] = mk(0, 0, 0,  1, 1, B + 64'h200,          1, B + 64'h200,   0, D2, B + 64'h100);
        tbl[17] = mk(1, 0, 0,  1, 1, B + 64'h302,          0, B + 64'h300,   0, D2, B + 64'h100);
        tbl[18] = mk(0, 1, DX, 1, 1, B + 64'h401,          1, B + 64'h400,   0, D2, B + 64'h100);
        tbl[19] = mk(1, 0, 0,  1, 0, 0,                    0, B + 64'h400,   0, D2, B + 64'h100);
        tbl[20] = mk(0, 1, D3, 0, 0, 0,                    0, B + 64'h400,   1, D3, B + 64'h400);
        tbl[21] = mk(0, 0, 0,  0, 1, B + 64'h500,          1, B + 64'h500,   0, D3, B + 64'h400);
        tbl[22] = mk(0, 1, DX, 1, 0, 0,                    1, B + 64'h500,   0, D3, B + 64'h400);
        tbl[23] = mk(0, 0, 0,  1, 1, B + 64'h600,          1, B + 64'h600,   0, D3, B + 64'h400);
        tbl[24] = mk(1, 0, 0,  1, 0, 0,                    0, B + 64'h600,   0, D3, B + 64'h400);
        tbl[25] = mk(0, 1, D4, 0, 0, 0,                    0, B + 64'h600,   1, D4, B + 64'h600);
        tbl[26] = mk(1, 0, 0,  1, 0, 0,                    1, B + 64'h604,   0, D4, B + 64'h600);
        tbl[27] = mk(0, 0, 0,  1, 1, 64'hffff_ffff_ffff_ffff, 1, TF,         0, D4, B + 64'h600);
        tbl[28] = mk(1, 0, 0,  1, 0, 0,                    0, TF,            0, D4, B + 64'h600);
        tbl[29] = mk(0, 1, D5, 0, 0, 0,                    0, TF,            1, D5, TF);
        tbl[30] = mk(0, 0, 0,  1, 0, 0,                    1, 64'h0,         0, D5, TF);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, B, 0, 0, 0);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                     tbl[i].e_ins, tbl[i].e_pc);
        end

        // Reset while a fetch is outstanding; the late rvalid must be ignored.
        @(negedge clk); drive(1, 0, 0, 1, 0, 0);
        @(posedge clk); #1; chk_outs("rst_seq.wait", 0, 64'h0, 0, D5, TF);
        @(negedge clk); rst = 1'b1; drive(0, 0, 0, 1, 0, 0);
        @(posedge clk); #1; chk_outs("rst_seq.in_rst", 0, B, 0, 0, 0);
        @(negedge clk); drive(0, 1, DX, 1, 0, 0);
        @(posedge clk); #1; chk_outs("rst_seq.rv_in_rst", 0, B, 0, 0, 0);
        @(negedge clk); rst = 1'b0; drive(0, 1, DX, 1, 0, 0);
        @(posedge clk); #1; chk_outs("rst_seq.rv_idle", 1, B, 0, 0, 0);
        @(negedge clk); drive(0, 1, DX, 1, 0, 0);
        @(posedge clk); #1; chk_outs("rst_seq.req", 1, B, 0, 0, 0);

        m_started = 1; m_out = 0; m_have = 0; m_stale = 0;
        m_pc = B; m_ins = 0; m_ins_pc = 0;
        mem_busy = 0; mem_cnt = 0; mem_a = 0;

        for (int c = 0; c < 4000; c++) begin
            logic        g, rv, rdy, rdr, issuing;
            logic [31:0] rd;
            logic [63:0] rpc, tgt;
            @(negedge clk);
            issuing = m_started && !m_out && !m_have;
            g   = issuing ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            if (mem_busy) begin
                rv = (mem_cnt == 0);
                rd = memfn(mem_a);
            end else begin
                rv = ($urandom_range(0, 7) == 0);
                rd = $urandom;
            end
            rdy = ($urandom_range(0, 2) != 0);
            rdr = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 0) rpc = B | 64'($urandom_range(0, 1023));
            else                          rpc = {$urandom, $urandom};
            drive(g, rv, rd, rdy, rdr, rpc);

            if (mem_busy) begin
                if (mem_cnt == 0) mem_busy = 0;
                else              mem_cnt--;
            end else if (issuing && g) begin
                mem_busy = 1;
                mem_a    = m_pc;
                mem_cnt  = $urandom_range(0, 3);
            end

            tgt = {rpc[63:2], 2'b00};
            if (rdr) begin
                m_pc      = tgt;
                m_have    = 0;
                m_started = 1;
                if (m_out) begin
                    if (rv) begin m_out = 0; m_stale = 0; end
                    else    m_stale = 1;
                end else if (issuing && g) begin
                    m_out   = 1;
                    m_stale = 1;
                end
            end else if (!m_started) begin
                m_started = 1;
            end else if (issuing && g) begin
                m_out = 1;
            end else if (m_out && rv) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else begin m_have = 1; m_ins = rd; m_ins_pc = m_pc; end
            end else if (m_have && rdy) begin
                m_have = 0;
                m_pc   = m_pc + 64'd4;
            end

            @(posedge clk);
            #1;
            chk_outs($sformatf("rnd%0d", c), m_started && !m_out && !m_have, m_pc, m_have,
                     m_ins, m_ins_pc);
            if (ins_valid) chk($sformatf("rnd%0d.data_vs_pc", c), {32'd0, ins}, {32'd0, memfn(ins_pc)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
